// File: rtl/tb_mmio_pkg.sv
// Shared register map, magic values and response payload for the testbench status peripheral.
package tb_mmio_pkg;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned BE_W      = 4;
  localparam int unsigned CHAR_W    = 8;
  localparam int unsigned CNT_W     = 64;
  localparam int unsigned NUM_REGS  = 8;
  localparam int unsigned REG_IDX_W = 3;

  localparam logic [ADDR_W-1:0] BASE_ADDR_DEF  = 32'h1000_0000;
  localparam logic [DATA_W-1:0] PASS_MAGIC_DEF = 32'd123456789;
  localparam logic [DATA_W-1:0] FAIL_MAGIC_DEF = 32'd1;

  localparam logic [4:0] OFF_PRINT     = 5'h00;
  localparam logic [4:0] OFF_TEST_STAT = 5'h04;
  localparam logic [4:0] OFF_EXIT      = 5'h08;
  localparam logic [4:0] OFF_CYCLE_LO  = 5'h0C;
  localparam logic [4:0] OFF_CYCLE_HI  = 5'h10;
  localparam logic [4:0] OFF_FIFO_LVL  = 5'h14;

  typedef enum logic [REG_IDX_W-1:0] {
    REG_PRINT     = 3'd0,
    REG_TEST_STAT = 3'd1,
    REG_EXIT      = 3'd2,
    REG_CYCLE_LO  = 3'd3,
    REG_CYCLE_HI  = 3'd4,
    REG_FIFO_LVL  = 3'd5,
    REG_RSVD6     = 3'd6,
    REG_RSVD7     = 3'd7
  } reg_idx_e;

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] rdata;
  } bus_rsp_t;

  // The window is 32-byte aligned, so only the bits above the 8-word offset are compared.
  function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                     input logic [ADDR_W-1:0] base);
    return addr[ADDR_W-1:5] == base[ADDR_W-1:5];
  endfunction

endpackage

// File: rtl/tb_char_fifo.sv
// Flop-based first-word-fall-through byte FIFO with wrap-bit pointers and a level output.
module tb_char_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  output logic                   full_o,
  output logic                   valid_o,
  output logic [WIDTH-1:0]       data_o,
  input  logic                   ready_i,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic             push_ok;
  logic             pop;

  // Status comes straight from the pointers; the head entry is always presented.
  always_comb begin
    level_o = wptr_q - rptr_q;
    full_o  = level_o == PW'(DEPTH);
    valid_o = level_o != '0;
    data_o  = mem_q[rptr_q[AW-1:0]];
    push_ok = push_i & ~full_o;
    pop     = valid_o & ready_i;

    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_ok) begin
      mem_d[wptr_q[AW-1:0]] = data_i;
      wptr_d                = wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/tb_mmio_status_periph.sv
// Bus slave for the core data port: stdout FIFO, sticky test/exit flags and a free-running cycle counter.
module tb_mmio_status_periph
  import tb_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = BASE_ADDR_DEF,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [31:0] PASS_MAGIC = PASS_MAGIC_DEF,
  parameter logic [31:0] FAIL_MAGIC = FAIL_MAGIC_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              data_req_i,
  output logic              data_gnt_o,
  input  logic              data_we_i,
  input  logic [BE_W-1:0]   data_be_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  output logic              data_rvalid_o,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic              data_err_o,
  output logic              char_valid_o,
  output logic [CHAR_W-1:0] char_o,
  input  logic              char_ready_i,
  output logic              tests_passed_o,
  output logic              tests_failed_o,
  output logic              exit_valid_o,
  output logic [DATA_W-1:0] exit_value_o
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              in_win;
  reg_idx_e          idx;
  logic              bad_reg;
  logic              print_wr;
  logic              fifo_push;
  logic              fifo_full;
  logic [LVL_W-1:0]  fifo_level;

  logic              rvalid_q, rvalid_d;
  bus_rsp_t          rsp_q, rsp_d;
  logic              passed_q, passed_d;
  logic              failed_q, failed_d;
  logic              exit_valid_q, exit_valid_d;
  logic [DATA_W-1:0] exit_value_q, exit_value_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic unused_bits;
  assign unused_bits = ^{data_be_i[BE_W-1:1], data_addr_i[1:0]};

  // Decode and grant; a PRINT write is held off while the FIFO is full so no byte is lost.
  always_comb begin
    in_win     = in_window(data_addr_i, BASE_ADDR);
    idx        = reg_idx_e'(data_addr_i[4:2]);
    bad_reg    = ~in_win | (idx == REG_RSVD6) | (idx == REG_RSVD7);
    print_wr   = data_req_i & data_we_i & in_win & (idx == REG_PRINT);
    data_gnt_o = data_req_i & ~(print_wr & fifo_full);
    fifo_push  = data_gnt_o & print_wr & data_be_i[0];
  end

  tb_char_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CHAR_W)
  ) u_char_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .data_i  (data_wdata_i[CHAR_W-1:0]),
    .full_o  (fifo_full),
    .valid_o (char_valid_o),
    .data_o  (char_o),
    .ready_i (char_ready_i),
    .level_o (fifo_level)
  );

  // Response register, register-file side effects and cycle counter.
  always_comb begin
    rvalid_d     = data_gnt_o;
    rsp_d        = '0;
    passed_d     = passed_q;
    failed_d     = failed_q;
    exit_valid_d = exit_valid_q;
    exit_value_d = exit_value_q;
    cnt_d        = cnt_q + CNT_W'(1);

    if (data_gnt_o) begin
      if (bad_reg) begin
        rsp_d.err = 1'b1;
      end else if (data_we_i) begin
        case (idx)
          REG_TEST_STAT: begin
            if (!passed_q && !failed_q) begin
              if (data_wdata_i == PASS_MAGIC) begin
                passed_d = 1'b1;
              end else if (data_wdata_i == FAIL_MAGIC) begin
                failed_d = 1'b1;
              end
            end
          end
          REG_EXIT: begin
            if (!exit_valid_q) begin
              exit_valid_d = 1'b1;
              exit_value_d = data_wdata_i;
            end
          end
          default: ;
        endcase
      end else begin
        case (idx)
          REG_TEST_STAT: rsp_d.rdata = {30'b0, failed_q, passed_q};
          REG_EXIT:      rsp_d.rdata = exit_value_q;
          REG_CYCLE_LO:  rsp_d.rdata = cnt_q[31:0];
          REG_CYCLE_HI:  rsp_d.rdata = cnt_q[63:32];
          REG_FIFO_LVL:  rsp_d.rdata = DATA_W'(fifo_level);
          default:       rsp_d.rdata = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q     <= 1'b0;
      rsp_q        <= '0;
      passed_q     <= 1'b0;
      failed_q     <= 1'b0;
      exit_valid_q <= 1'b0;
      exit_value_q <= '0;
      cnt_q        <= '0;
    end else begin
      rvalid_q     <= rvalid_d;
      rsp_q        <= rsp_d;
      passed_q     <= passed_d;
      failed_q     <= failed_d;
      exit_valid_q <= exit_valid_d;
      exit_value_q <= exit_value_d;
      cnt_q        <= cnt_d;
    end
  end

  assign data_rvalid_o  = rvalid_q;
  assign data_rdata_o   = rsp_q.rdata;
  assign data_err_o     = rsp_q.err;
  assign tests_passed_o = passed_q;
  assign tests_failed_o = failed_q;
  assign exit_valid_o   = exit_valid_q;
  assign exit_value_o   = exit_value_q;

endmodule

// File: tb/tb_tb_mmio_status_periph.sv
// Directed and randomized bench for tb_mmio_status_periph against a queue/flag reference model.
module tb_tb_mmio_status_periph;

  localparam logic [31:0] BASE   = 32'h1000_0000;
  localparam int unsigned DEPTH  = 16;
  localparam logic [31:0] PASS_V = 32'd123456789;
  localparam logic [31:0] FAIL_V = 32'd1;

  logic        clk, rst;
  logic        req, gnt, we;
  logic [3:0]  be;
  logic [31:0] addr, wdata, rdata;
  logic        rvalid, err;
  logic        char_valid, char_ready;
  logic [7:0]  char_b;
  logic        passed, failed, exit_valid;
  logic [31:0] exit_value;

  logic rand_mode, rand_bit, ready_man;
  assign char_ready = rand_mode ? rand_bit : ready_man;

  int          total, bad;
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  int          got_base;
  logic        m_passed, m_failed, m_exit_valid;
  logic [31:0] m_exit_value;
  time         t_rel;

  tb_mmio_status_periph #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH),
    .PASS_MAGIC (PASS_V),
    .FAIL_MAGIC (FAIL_V)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .data_req_i     (req),
    .data_gnt_o     (gnt),
    .data_we_i      (we),
    .data_be_i      (be),
    .data_addr_i    (addr),
    .data_wdata_i   (wdata),
    .data_rvalid_o  (rvalid),
    .data_rdata_o   (rdata),
    .data_err_o     (err),
    .char_valid_o   (char_valid),
    .char_o         (char_b),
    .char_ready_i   (char_ready),
    .tests_passed_o (passed),
    .tests_failed_o (failed),
    .exit_valid_o   (exit_valid),
    .exit_value_o   (exit_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rand_bit = 1'($urandom_range(0, 1));
  end

  // Console sink: record every byte handed over (pop happens at the following rising edge).
  always @(negedge clk) begin
    if (rst === 1'b0 && char_valid === 1'b1 && char_ready === 1'b1) got_q.push_back(char_b);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One bus transaction; returns response, grant edge time and pops completed before the grant edge.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, output logic [31:0] rd, output logic er,
                        output time tg, output int popped);
    int waited;
    rd = '0; er = 1'b0; tg = 0; popped = 0;
    @(posedge clk); #1;
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    waited = 0;
    @(negedge clk); #1;
    while (gnt !== 1'b1 && waited < 300) begin
      waited++;
      @(negedge clk); #1;
    end
    if (gnt !== 1'b1) begin
      check("gnt_timeout", 64'(gnt), 64'd1);
      req = 1'b0;
      return;
    end
    popped = got_q.size();
    @(posedge clk);
    tg = $time;
    #1;
    req = 1'b0; we = 1'b0;
    check("rvalid_after_grant", 64'(rvalid), 64'd1);
    rd = rdata; er = err;
    @(posedge clk); #1;
    check("rvalid_single_pulse", 64'(rvalid), 64'd0);
  endtask

  task automatic bus_op(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b);
    logic [31:0] rd, rel, exp_rd;
    logic        er, in_win, exp_er;
    time         tg;
    int          popped, off;
    rel    = a - BASE;
    in_win = rel < 32'd32;
    off    = int'(rel[4:2]);
    if (!w && in_win && off == 5) begin
      rand_mode = 1'b0;
      ready_man = 1'b0;
    end
    access(w, a, d, b, rd, er, tg, popped);
    exp_er = !in_win || off >= 6;
    exp_rd = '0;
    if (!exp_er && !w) begin
      case (off)
        1: exp_rd = {30'b0, m_failed, m_passed};
        2: exp_rd = m_exit_value;
        3: exp_rd = 32'((tg - t_rel - 9) / 10);
        5: exp_rd = 32'(exp_q.size() - (popped - got_base));
        default: exp_rd = '0;
      endcase
    end
    check({tag, "_err"}, 64'(er), 64'(exp_er));
    check({tag, "_rdata"}, 64'(rd), 64'(exp_rd));
    if (w && !exp_er) begin
      case (off)
        0: if (b[0]) exp_q.push_back(d[7:0]);
        1: if (!m_passed && !m_failed) begin
             if (d == PASS_V) m_passed = 1'b1;
             else if (d == FAIL_V) m_failed = 1'b1;
           end
        2: if (!m_exit_valid) begin
             m_exit_valid = 1'b1;
             m_exit_value = d;
           end
        default: ;
      endcase
    end
    check({tag, "_passed"}, 64'(passed), 64'(m_passed));
    check({tag, "_failed"}, 64'(failed), 64'(m_failed));
    check({tag, "_exit_valid"}, 64'(exit_valid), 64'(m_exit_valid));
    check({tag, "_exit_value"}, 64'(exit_value), 64'(m_exit_value));
  endtask

  // Let the sink drain, then compare the emitted bytes with the expected stream in order.
  task automatic compare_stream(input string tag);
    int n, waited;
    n = exp_q.size();
    waited = 0;
    while ((got_q.size() - got_base) < n && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    check({tag, "_count"}, 64'(got_q.size() - got_base), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (got_base + i < got_q.size()) check({tag, "_byte"}, 64'(got_q[got_base + i]), 64'(exp_q[i]));
    end
    got_base = got_q.size();
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, 64'(gnt), 64'd0);
    check({tag, "_rvalid"}, 64'(rvalid), 64'd0);
    check({tag, "_rdata"}, 64'(rdata), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_char_valid"}, 64'(char_valid), 64'd0);
    check({tag, "_passed"}, 64'(passed), 64'd0);
    check({tag, "_failed"}, 64'(failed), 64'd0);
    check({tag, "_exit_valid"}, 64'(exit_valid), 64'd0);
    check({tag, "_exit_value"}, 64'(exit_value), 64'd0);
  endtask

  initial begin
    logic [7:0]  b8;
    logic [31:0] a, d;
    logic        w;
    int          r;

    rst = 1'b1; req = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0;
    rand_mode = 1'b0; ready_man = 1'b0;
    total = 0; bad = 0; got_base = 0;
    m_passed = 1'b0; m_failed = 1'b0; m_exit_valid = 1'b0; m_exit_value = '0;
    t_rel = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    t_rel = $time;

    // Two stdout bytes with the sink ready.
    ready_man = 1'b1;
    bus_op("print_h", 1'b1, BASE, 32'h0000_0048, 4'hF);
    bus_op("print_i", 1'b1, BASE + 32'd1, 32'hABCD_0069, 4'h1);
    compare_stream("hi_stream");

    // Fill the FIFO with the sink stalled, then one extra write must wait for space.
    ready_man = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      b8 = 8'($urandom);
      bus_op("fill", 1'b1, BASE, {24'($urandom), b8}, 4'h1);
    end
    bus_op("lvl_full", 1'b0, BASE + 32'h14, 32'h0, 4'hF);
    b8 = 8'($urandom);
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; addr = BASE; wdata = {24'h0, b8}; be = 4'h1;
    @(negedge clk); #1;
    check("full_gnt_withheld", 64'(gnt), 64'd0);
    @(posedge clk); #1;
    ready_man = 1'b1;
    @(negedge clk); #1;
    check("full_pop_gnt_withheld", 64'(gnt), 64'd0);
    @(negedge clk); #1;
    check("gnt_after_pop", 64'(gnt), 64'd1);
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
    check("stall_write_rvalid", 64'(rvalid), 64'd1);
    exp_q.push_back(b8);
    compare_stream("full_stream");

    // Sticky pass flag and readback.
    bus_op("stat_pass", 1'b1, BASE + 32'h4, PASS_V, 4'hF);
    bus_op("stat_fail_ignored", 1'b1, BASE + 32'h4, FAIL_V, 4'hF);
    bus_op("stat_read", 1'b0, BASE + 32'h4, 32'h0, 4'hF);
    check("stat_passed_high", 64'(passed), 64'd1);

    // First exit write wins.
    bus_op("exit_5", 1'b1, BASE + 32'h8, 32'h5, 4'hF);
    bus_op("exit_0", 1'b1, BASE + 32'h8, 32'h0, 4'hF);
    bus_op("exit_read", 1'b0, BASE + 32'h8, 32'h0, 4'hF);
    check("exit_value_held", 64'(exit_value), 64'd5);

    // Error responses: reserved offsets and addresses outside the window.
    bus_op("rd_off18", 1'b0, BASE + 32'h18, 32'h0, 4'hF);
    bus_op("rd_base40", 1'b0, BASE + 32'h40, 32'h0, 4'hF);
    bus_op("wr_off1c", 1'b1, BASE + 32'h1C, PASS_V, 4'hF);
    bus_op("rd_below", 1'b0, BASE - 32'h4, 32'h0, 4'hF);
    bus_op("cyc_hi", 1'b0, BASE + 32'h10, 32'h0, 4'hF);

    // Reset with bytes queued, exit set and a response in flight.
    ready_man = 1'b0;
    for (int i = 0; i < 3; i++) bus_op("pre_rst_print", 1'b1, BASE, 32'($urandom_range(0, 255)), 4'h1);
    check("pre_rst_char_valid", 64'(char_valid), 64'd1);
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; addr = BASE + 32'h8; be = 4'hF;
    @(negedge clk); #1;
    check("rst_txn_gnt", 64'(gnt), 64'd1);
    @(posedge clk); #1;
    req = 1'b0;
    check("rst_txn_rvalid_pre", 64'(rvalid), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_txn_rvalid_cleared", 64'(rvalid), 64'd0);
    @(negedge clk);
    check_all_zero("mid_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    t_rel = $time;
    m_passed = 1'b0; m_failed = 1'b0; m_exit_valid = 1'b0; m_exit_value = '0;
    got_base = got_q.size();
    exp_q.delete();
    repeat (9) @(posedge clk);
    bus_op("cyc_lo_after_rst", 1'b0, BASE + 32'h0C, 32'h0, 4'hF);
    bus_op("lvl_after_rst", 1'b0, BASE + 32'h14, 32'h0, 4'hF);

    // Randomized traffic over the whole map with a randomly stalling sink.
    for (int i = 0; i < 120; i++) begin
      rand_mode = 1'b1;
      r = int'($urandom_range(0, 9));
      if (r < 8) a = BASE + 32'(r * 4) + 32'($urandom_range(0, 3));
      else if (r == 8) a = BASE + 32'd32 + 32'($urandom_range(0, 255));
      else a = $urandom;
      w = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: d = PASS_V;
        1: d = FAIL_V;
        default: d = $urandom;
      endcase
      bus_op("rand", w, a, d, 4'($urandom_range(0, 15)));
    end
    rand_mode = 1'b0;
    ready_man = 1'b1;
    compare_stream("rand_stream");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
